// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 slave with one-byte TX holding buffer and
// one-byte RX output register. SPI pins are synchronized into clk30.
//
// Ports:
//   clk30, reset          system clock, synchronous active-high reset
//   spi_sck/ss_n/mosi     asynchronous SPI master inputs
//   spi_miso              slave data out (1 while deselected)
//   tx_data/valid/ready   response byte handshake into holding buffer
//   rx_data/valid/ready   received byte handshake
//   rx_overrun(_clr)      sticky lost-byte flag and its clear
//   busy                  high while in SHIFT
module spi_slave_responder #(
    parameter logic [7:0]  IDLE_FILL   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk30,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       rx_overrun_clr,
    output logic       busy
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                 sck_dly_q, ss_dly_q;
    logic                 busy_q, miso_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BYTE_W-1:0]    tx_sh_q, rx_sh_q, buf_q, rx_data_q;
    logic                 tx_ready_q, rx_valid_q, rx_overrun_q;

    logic                 sck_s, ss_s, mosi_s;
    logic                 sck_rise, sck_fall, ss_fall, ss_rise;
    logic                 in_shift, load, byte_done, fill, rx_free;
    logic [BYTE_W-1:0]    rx_byte, tx_sh_d;

    // Edge detection on the last synchronizer stage vs. one extra delay flop
    always_comb begin
        sck_s     = sck_sync_q[SYNC_STAGES-1];
        ss_s      = ss_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sck_rise  = sck_s & ~sck_dly_q;
        sck_fall  = ~sck_s & sck_dly_q;
        ss_fall   = ~ss_s & ss_dly_q;
        ss_rise   = ss_s & ~ss_dly_q;
        // Deselect wins over any SCK edge seen in the same cycle
        in_shift  = (state_q == SHIFT) && !ss_rise;
        // Load on frame start and on the falling edge after every 8th bit
        load      = ((state_q == IDLE) && ss_fall) ||
                    (in_shift && sck_fall && (cnt_q == CNT_W'(0)));
        byte_done = in_shift && sck_rise && (cnt_q == CNT_W'(7));
        fill      = tx_valid && tx_ready_q;
        rx_byte   = {rx_sh_q[BYTE_W-2:0], mosi_s};
        rx_free   = !rx_valid_q || rx_ready;
    end

    // TX shift register next value; a load takes the pre-fill buffer content
    always_comb begin
        tx_sh_d = tx_sh_q;
        if (load) begin
            tx_sh_d = tx_ready_q ? IDLE_FILL : buf_q;
        end else if (in_shift && sck_fall) begin
            tx_sh_d = {tx_sh_q[BYTE_W-2:0], 1'b0};
        end
    end

    // Synchronizers, FSM, buffers and registered outputs
    always_ff @(posedge clk30) begin
        if (reset) begin
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            mosi_sync_q  <= '1;
            sck_dly_q    <= 1'b0;
            ss_dly_q     <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            miso_q       <= 1'b1;
            cnt_q        <= '0;
            tx_sh_q      <= '0;
            rx_sh_q      <= '0;
            buf_q        <= '0;
            tx_ready_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_dly_q   <= sck_s;
            ss_dly_q    <= ss_s;

            tx_sh_q <= tx_sh_d;
            // Stage SYNC_STAGES-2 becomes the synchronized ss_n next cycle
            miso_q  <= ss_sync_q[SYNC_STAGES-2] ? 1'b1 : tx_sh_d[BYTE_W-1];

            if (fill) begin
                buf_q      <= tx_data;
                tx_ready_q <= 1'b0;
            end else if (load) begin
                tx_ready_q <= 1'b1;
            end

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_overrun_clr) begin
                rx_overrun_q <= 1'b0;
            end
            if (byte_done) begin
                if (rx_free) begin
                    rx_data_q  <= rx_byte;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        rx_sh_q <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        // Partial byte dropped; loaded TX byte is not restored
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        rx_sh_q <= '0;
                    end else if (sck_rise) begin
                        rx_sh_q <= rx_byte;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign spi_miso   = miso_q;
    assign tx_ready   = tx_ready_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: an SPI mode-0 master model drives
// frames, captured MISO bytes and handshake outputs are checked against
// hand-computed values.
module tb_spi_slave_responder;

    localparam int unsigned HALF = 80;  // SCK half period in ns (clk30 = 10 ns)

    logic       clk30 = 1'b0;
    logic       reset;
    logic       spi_sck, spi_ss_n, spi_mosi, spi_miso;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overrun, rx_overrun_clr, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] mo [3];
    logic [7:0] mi [3];

    spi_slave_responder #(.IDLE_FILL(8'hFF), .SYNC_STAGES(2)) dut (
        .clk30          (clk30),
        .reset          (reset),
        .spi_sck        (spi_sck),
        .spi_ss_n       (spi_ss_n),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_overrun     (rx_overrun),
        .rx_overrun_clr (rx_overrun_clr),
        .busy           (busy)
    );

    always #5 clk30 = ~clk30;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift nbits of mo_b out on MOSI, sampling MISO just before each rising edge
    task automatic spi_bits(input logic [7:0] mo_b, input int nbits, output logic [7:0] mi_b);
        logic [7:0] sh;
        sh   = mo_b;
        mi_b = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = sh[7];
            sh       = {sh[6:0], 1'b0};
            #(HALF);
            mi_b     = {mi_b[6:0], spi_miso};
            spi_sck  = 1'b1;
            #(HALF);
            spi_sck  = 1'b0;
        end
    endtask

    task automatic frame(input int n);
        logic [7:0] r;
        spi_ss_n = 1'b0;
        #(HALF);
        for (int b = 0; b < n; b++) begin
            spi_bits(mo[b], 8, r);
            mi[b] = r;
        end
        #(HALF);
        spi_ss_n = 1'b1;
        spi_mosi = 1'b1;
        #(HALF);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk30);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk30);
        tx_valid = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk30);
        rx_ready = 1'b1;
        @(negedge clk30);
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     {7'd0, busy},       8'h00);
        check({tag, "_miso"},     {7'd0, spi_miso},   8'h01);
        check({tag, "_tx_ready"}, {7'd0, tx_ready},   8'h01);
        check({tag, "_rx_data"},  rx_data,            8'h00);
        check({tag, "_rx_valid"}, {7'd0, rx_valid},   8'h00);
        check({tag, "_overrun"},  {7'd0, rx_overrun}, 8'h00);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] junk;
        reset = 1'b1; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b1;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; rx_overrun_clr = 1'b0;
        repeat (3) @(negedge clk30);
        check_reset_values("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk30);
        check("idle_miso", {7'd0, spi_miso}, 8'h01);

        // Buffered response byte
        push(8'hEE);
        check("pushed_tx_ready", {7'd0, tx_ready}, 8'h00);
        mo[0] = 8'hDD;
        frame(1);
        check("t1_miso",     mi[0],               8'hEE);
        check("t1_rx_data",  rx_data,             8'hDD);
        check("t1_rx_valid", {7'd0, rx_valid},    8'h01);
        check("t1_tx_ready", {7'd0, tx_ready},    8'h01);
        check("t1_busy",     {7'd0, busy},        8'h00);
        consume();
        check("t1_consumed", {7'd0, rx_valid},    8'h00);

        // Empty buffer sends the idle fill
        mo[0] = 8'h57;
        frame(1);
        check("t2_miso",    mi[0],   8'hFF);
        check("t2_rx_data", rx_data, 8'h57);
        consume();

        // Overrun: consumer stalls across a 3-byte frame
        mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03;
        frame(3);
        check("t3_rx_data",  rx_data,            8'h01);
        check("t3_rx_valid", {7'd0, rx_valid},   8'h01);
        check("t3_overrun",  {7'd0, rx_overrun}, 8'h01);
        @(negedge clk30);
        rx_overrun_clr = 1'b1;
        @(negedge clk30);
        rx_overrun_clr = 1'b0;
        consume();
        check("t3_clr_valid",   {7'd0, rx_valid},   8'h00);
        check("t3_clr_overrun", {7'd0, rx_overrun}, 8'h00);

        // Back-to-back responses: second byte pushed while the first shifts
        push(8'hA5);
        mo[0] = 8'h11; mo[1] = 8'h22;
        fork
            frame(2);
            begin
                #400;
                push(8'h5A);
            end
        join
        check("t4_miso0",    mi[0],            8'hA5);
        check("t4_miso1",    mi[1],            8'h5A);
        check("t4_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("t4_rx_data",  rx_data,          8'h11);
        consume();
        @(negedge clk30);
        rx_overrun_clr = 1'b1;
        @(negedge clk30);
        rx_overrun_clr = 1'b0;

        // Aborted byte: deselect after 4 bits
        spi_ss_n = 1'b0;
        #(HALF);
        spi_bits(8'hF0, 4, junk);
        #(HALF);
        spi_ss_n = 1'b1;
        spi_mosi = 1'b1;
        #(HALF);
        check("t5_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("t5_busy",     {7'd0, busy},     8'h00);
        check("t5_miso",     {7'd0, spi_miso}, 8'h01);
        mo[0] = 8'h3C;
        frame(1);
        check("t5_rx_data",  rx_data,          8'h3C);
        check("t5_rx_valid2", {7'd0, rx_valid}, 8'h01);
        consume();

        // Reset mid-byte, then a clean frame
        spi_ss_n = 1'b0;
        #(HALF);
        spi_bits(8'h66, 5, junk);
        @(negedge clk30);
        reset = 1'b1;
        repeat (2) @(negedge clk30);
        check_reset_values("t6_rst");
        spi_ss_n = 1'b1;
        spi_mosi = 1'b1;
        @(negedge clk30);
        reset = 1'b0;
        repeat (4) @(negedge clk30);
        mo[0] = 8'h99;
        frame(1);
        check("t6_rx_data",  rx_data,            8'h99);
        check("t6_rx_valid", {7'd0, rx_valid},   8'h01);
        check("t6_overrun",  {7'd0, rx_overrun}, 8'h00);
        check("t6_miso",     mi[0],              8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
